amba_master: RTL and testbench
==============================

AMBA_MASTER -- requirements
Module: amba_master

Interface
REQ-001 Parameter: DATA_W, 128, HWDATA/HRDATA width; SHALL match HSIZE=3'b100.
REQ-002 Parameter: MAX_WAIT, 16, data-phase wait cycles allowed before timeout.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Ports: req_valid in 1; req_ready out 1; req_write in 1 (high=write, low=read); req_addr in 32; req_wdata in DATA_W; request side.
REQ-006 Ports: rsp_valid out 1; rsp_rdata out DATA_W; rsp_err out 1; rsp_timeout out 1; response side.
REQ-007 Ports: HADDR out 32; HBURST out 3; HMASTLOCK out 1; HPORT out 4; HSIZE out 3; HTRANS out 2; HWRITE out 1; HWDATA out DATA_W; HSELx out 1; AHB-Lite master outputs.
REQ-008 Ports: HREADY in 1; HRESP in 1; HRDATA in DATA_W; AHB-Lite slave returns.

Function
REQ-009 The block SHALL be the initiator for the AHB sensor slave: single transfers only, HBURST=3'b000, HSIZE=3'b100, HMASTLOCK=0, HPORT=4'b0011 constant.
REQ-010 FSM states SHALL be IDLE, ADDR, DATA, ERR; all AHB outputs and rsp_* SHALL be registered.
REQ-011 IDLE: req_ready=1, HTRANS=2'b00, HSELx=0; on req_valid, latch addr/write/wdata and go to ADDR.
REQ-012 Misaligned request (req_addr[3:0]!=0) SHALL NOT reach the bus: stay IDLE, pulse rsp_valid=1 with rsp_err=1 the next cycle.
REQ-013 ADDR (exactly one cycle when HREADY=1): HADDR=latched addr, HTRANS=2'b10 (NONSEQ), HWRITE=latched write, HSELx=1; if HREADY=0, hold all address signals unchanged and remain in ADDR.
REQ-014 DATA: HTRANS=2'b00, HSELx=0, HWDATA=latched wdata held stable; wait counter increments each cycle HREADY=0.
REQ-015 DATA with HREADY=1, HRESP=0: rsp_valid=1 for one cycle, rsp_rdata=HRDATA for reads (all zero for writes), return to IDLE.
REQ-016 DATA with HREADY=0, HRESP=1: go to ERR; ERR with HREADY=1: rsp_valid=1, rsp_err=1, return to IDLE.
REQ-017 Wait counter reaching MAX_WAIT in DATA SHALL abandon the transfer: rsp_valid=1, rsp_timeout=1, return to IDLE; counter clears on every entry to ADDR.
REQ-018 req_ready SHALL be 0 in ADDR, DATA, ERR; requests there are ignored, not queued.
REQ-019 Minimum write latency: accept at edge N, address phase N+1, rsp_valid at edge N+3 with zero wait states.
REQ-020 rsp_err and rsp_timeout SHALL never both be 1; both SHALL be 0 whenever rsp_valid=0.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, HTRANS=2'b00, HSELx=0, HWRITE=0, HADDR=0, HWDATA=0, rsp_*=0, req_ready=0 while asserted, counter=0.
REQ-022 Reset mid-transfer SHALL drop the transfer with no response; req_ready=1 the first cycle after deassertion.

Structure
REQ-023 Shared package amba_pkg SHALL hold HTRANS/HBURST/HSIZE encodings, HPORT value, the FSM state typedef, and sensor address 32'hF0F0F0F0.
REQ-024 One sub-module, wait_counter (clear, enable, terminal-count output, MAX_WAIT parameter), SHALL implement the timeout.

Verification
REQ-025 Write 0xF0F0F0F0, zero wait -> one NONSEQ cycle, HBURST=000, HSIZE=100, HWRITE=1; rsp_valid three cycles after accept, rsp_err=0.
REQ-026 Read 0xF0F0F0F0, HREADY low 3 cycles, HRDATA=0xA5..A5 -> HWDATA/HADDR stable, rsp_rdata=0xA5..A5 after the 4th data cycle.
REQ-027 Two-cycle ERROR response (HRESP=1, HREADY 0 then 1) -> rsp_valid=1, rsp_err=1, FSM IDLE, req_ready=1.
REQ-028 HREADY held 0 for MAX_WAIT=16 cycles -> rsp_timeout=1 on cycle 16, HTRANS=00.
REQ-029 Request addr 0xF0F0F0F4 -> no NONSEQ on bus, rsp_err=1 next cycle.
REQ-030 rst asserted during DATA -> HTRANS=00, HSELx=0 immediately, no rsp_valid afterwards.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AHB-Lite encodings, fixed attributes and FSM state type for the
// sensor-bus master.
package amba_pkg;

  localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
  localparam logic [2:0]  HSIZE_128       = 3'b100;
  localparam logic [3:0]  HPORT_DATA_PRIV = 4'b0011;
  localparam logic [31:0] SENSOR_ADDR     = 32'hF0F0_F0F0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // A 128-bit transfer must start on a 16-byte boundary.
  function automatic logic addr_aligned(input logic [3:0] low_bits);
    return (low_bits == 4'h0);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Counts stalled bus cycles and flags the cycle on which the limit is reached.
module wait_counter #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int               CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] TOP   = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Stall counter, saturating one past the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != TOP)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // High on the stalled cycle that would take the count to MAX_WAIT
  assign tc = enable && (count_r == LAST);

endmodule

// File: rtl/amba_master.sv
// AHB-Lite single-transfer master for the sensor slave: one request at a time,
// registered bus and response outputs, error and stall-timeout handling.
module amba_master
  import amba_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [31:0]       HADDR,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPORT,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HSELx,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  state_t state_r;
  logic   wait_clear_s;
  logic   wait_en_s;
  logic   wait_tc_s;

  assign HBURST    = HBURST_SINGLE;
  assign HSIZE     = HSIZE_128;
  assign HMASTLOCK = 1'b0;
  assign HPORT     = HPORT_DATA_PRIV;

  // Ready drops with reset and rises as soon as it is released
  assign req_ready = (state_r == ST_IDLE) && !rst;

  assign wait_clear_s = (state_r == ST_IDLE) || (state_r == ST_ADDR);
  assign wait_en_s    = ((state_r == ST_DATA) || (state_r == ST_ERR)) && !HREADY;

  wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear_s),
    .enable (wait_en_s),
    .tc     (wait_tc_s)
  );

  // Transfer FSM; every bus and response output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      HADDR       <= 32'h0000_0000;
      HTRANS      <= HTRANS_IDLE;
      HWRITE      <= 1'b0;
      HSELx       <= 1'b0;
      HWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid && !addr_aligned(req_addr[3:0])) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (req_valid) begin
            HADDR   <= req_addr;
            HWRITE  <= req_write;
            HWDATA  <= req_wdata;
            HTRANS  <= HTRANS_NONSEQ;
            HSELx   <= 1'b1;
            state_r <= ST_ADDR;
          end else begin
            HTRANS  <= HTRANS_IDLE;
            HSELx   <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS  <= HTRANS_IDLE;
            HSELx   <= 1'b0;
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            // A late-seen HRESP with HREADY high still reports an error
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP;
            rsp_rdata <= (HWRITE || HRESP) ? '0 : HRDATA;
            state_r   <= ST_IDLE;
          end else if (HRESP) begin
            state_r   <= ST_ERR;
          end else if (wait_tc_s) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DATA;
          end
        end
        ST_ERR: begin
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state_r   <= ST_IDLE;
          end else if (wait_tc_s) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_ERR;
          end
        end
        default: begin
          HTRANS  <= HTRANS_IDLE;
          HSELx   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amba_master.sv
// Scenario bench for amba_master: expected responses are queued when a request
// is driven and matched against responses captured from the DUT.
module tb_amba_master;
  import amba_pkg::*;

  localparam int DW = 128;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    bit            chk_data;
    int            edge_n;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [31:0]   HADDR;
  logic [2:0]    HBURST, HSIZE;
  logic          HMASTLOCK, HWRITE, HSELx, HREADY, HRESP;
  logic [3:0]    HPORT;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nonseq_cnt = 0;
  int   rsp_seen = 0;
  int   viol = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  rsp_t mon_r;

  amba_master #(.DATA_W(DW), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPORT(HPORT), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HSELx(HSELx),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: edge_n is the clock edge on which a consumer samples the response
  always @(posedge clk) begin
    #2;
    if (HTRANS === 2'b10) nonseq_cnt++;
    if (rsp_valid === 1'b1) begin
      mon_r.rdata = rsp_rdata; mon_r.err = rsp_err; mon_r.tmo = rsp_timeout;
      mon_r.chk_data = 1'b1; mon_r.edge_n = cyc + 1;
      obs_q.push_back(mon_r);
      rsp_seen++;
    end
    if ((rsp_err === 1'b1 && rsp_timeout === 1'b1) || (rsp_valid !== 1'b1 && (rsp_err !== 1'b0 || rsp_timeout !== 1'b0))) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [DW-1:0] d, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (obs_q.size() != 0) ok = 1'b1;
      else @(negedge clk);
    end
    if (obs_q.size() != 0) ok = 1'b1;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic err, input logic tmo, input bit cd, input int edge_n);
    rsp_t e;
    e.rdata = d; e.err = err; e.tmo = tmo; e.chk_data = cd; e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
    checks++; if (HSELx !== 1'b0) begin errors++; $display("FAIL reset_hsel got %b exp 0", HSELx); end
    checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL reset_hwrite got %b exp 0", HWRITE); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h exp 0", HADDR); end
    checks++; if (HWDATA !== '0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", HWDATA); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp got v=%b e=%b t=%b d=%h exp all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++; if ({HBURST, HSIZE, HMASTLOCK, HPORT} !== {3'b000, 3'b100, 1'b0, 4'b0011}) begin errors++; $display("FAIL const_attrs got burst=%b size=%b lock=%b port=%b exp 000 100 0 0011", HBURST, HSIZE, HMASTLOCK, HPORT); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", req_ready); end
  endtask

  task automatic test_write;
    rsp_t o, e; bit ok; int acc, ns0;
    logic [DW-1:0] wd;
    wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ns0 = nonseq_cnt;
    drive_req(1'b1, SENSOR_ADDR, wd, acc);
    push_exp('0, 1'b0, 1'b0, 1'b1, acc + 3);
    checks++; if ({HTRANS, HSELx, HWRITE, req_ready} !== {2'b10, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL wr_addr_phase got trans=%b sel=%b wr=%b rdy=%b exp 10 1 1 0", HTRANS, HSELx, HWRITE, req_ready); end
    checks++; if (HADDR !== SENSOR_ADDR) begin errors++; $display("FAIL wr_haddr got %h exp %h", HADDR, SENSOR_ADDR); end
    @(negedge clk);
    checks++; if ({HTRANS, HSELx, rsp_valid} !== {2'b00, 1'b0, 1'b0}) begin errors++; $display("FAIL wr_data_phase got trans=%b sel=%b v=%b exp 00 0 0", HTRANS, HSELx, rsp_valid); end
    checks++; if (HWDATA !== wd) begin errors++; $display("FAIL wr_hwdata got %h exp %h", HWDATA, wd); end
    wait_rsp(20, ok);
    checks++;
    if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL wr_rsp no response within budget"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL wr_rsp got d=%h e=%b t=%b edge=%0d exp d=%h e=%b t=%b edge=%0d", o.rdata, o.err, o.tmo, o.edge_n, e.rdata, e.err, e.tmo, e.edge_n); end
    end
    checks++; if (nonseq_cnt - ns0 !== 1) begin errors++; $display("FAIL wr_nonseq_count got %0d exp 1", nonseq_cnt - ns0); end
  endtask

  task automatic test_read_wait;
    rsp_t o, e; bit ok; int acc;
    logic [DW-1:0] wd, pat;
    wd = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    pat = {16{8'hA5}};
    HRDATA = {16{8'h11}};
    drive_req(1'b0, SENSOR_ADDR, wd, acc);
    push_exp(pat, 1'b0, 1'b0, 1'b1, acc + 6);
    checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL rd_hwrite got %b exp 0", HWRITE); end
    @(negedge clk);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (HWDATA !== wd || HADDR !== SENSOR_ADDR || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_stable[%0d] got wd=%h a=%h v=%b exp wd=%h a=%h v=0", i, HWDATA, HADDR, rsp_valid, wd, SENSOR_ADDR); end
      if (i == 2) begin HREADY = 1'b1; HRDATA = pat; end
    end
    wait_rsp(20, ok);
    checks++;
    if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL rd_rsp no response within budget"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL rd_rsp got d=%h e=%b t=%b edge=%0d exp d=%h e=%b t=%b edge=%0d", o.rdata, o.err, o.tmo, o.edge_n, e.rdata, e.err, e.tmo, e.edge_n); end
    end
    HRDATA = '0;
  endtask

  task automatic test_error;
    rsp_t o, e; bit ok; int acc;
    drive_req(1'b0, SENSOR_ADDR, '0, acc);
    push_exp('0, 1'b1, 1'b0, 1'b0, acc + 4);
    @(negedge clk);
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL err_first_cycle got v=%b rdy=%b exp 0 0", rsp_valid, req_ready); end
    HREADY = 1'b1;
    @(negedge clk);
    HRESP = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, req_ready} !== 4'b1101) begin errors++; $display("FAIL err_rsp_flags got v=%b e=%b t=%b rdy=%b exp 1 1 0 1", rsp_valid, rsp_err, rsp_timeout, req_ready); end
    wait_rsp(20, ok);
    checks++;
    if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL err_rsp no response within budget"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL err_rsp got e=%b t=%b edge=%0d exp e=%b t=%b edge=%0d", o.err, o.tmo, o.edge_n, e.err, e.tmo, e.edge_n); end
    end
  endtask

  task automatic test_timeout;
    rsp_t o, e; bit ok; int acc; bit early;
    early = 1'b0;
    drive_req(1'b1, SENSOR_ADDR, {4{32'hCAFE_F00D}}, acc);
    push_exp('0, 1'b0, 1'b1, 1'b0, acc + 18);
    @(negedge clk);
    HREADY = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_early got early=%b exp 0", early); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_timeout, rsp_err, HTRANS, req_ready} !== {1'b1, 1'b1, 1'b0, 2'b00, 1'b1}) begin errors++; $display("FAIL tmo_flags got v=%b t=%b e=%b trans=%b rdy=%b exp 1 1 0 00 1", rsp_valid, rsp_timeout, rsp_err, HTRANS, req_ready); end
    HREADY = 1'b1;
    wait_rsp(20, ok);
    checks++;
    if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL tmo_rsp no response within budget"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL tmo_rsp got e=%b t=%b edge=%0d exp e=%b t=%b edge=%0d", o.err, o.tmo, o.edge_n, e.err, e.tmo, e.edge_n); end
    end
  endtask

  task automatic test_misaligned;
    rsp_t o, e; bit ok; int acc, ns0;
    ns0 = nonseq_cnt;
    drive_req(1'b1, 32'hF0F0_F0F4, {4{32'h1234_5678}}, acc);
    push_exp('0, 1'b1, 1'b0, 1'b0, acc + 1);
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, req_ready, HTRANS} !== {4'b1101, 2'b00}) begin errors++; $display("FAIL mis_flags got v=%b e=%b t=%b rdy=%b trans=%b exp 1 1 0 1 00", rsp_valid, rsp_err, rsp_timeout, req_ready, HTRANS); end
    repeat (2) @(negedge clk);
    checks++; if (nonseq_cnt - ns0 !== 0) begin errors++; $display("FAIL mis_no_bus got nonseq=%0d exp 0", nonseq_cnt - ns0); end
    wait_rsp(20, ok);
    checks++;
    if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL mis_rsp no response within budget"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL mis_rsp got e=%b t=%b edge=%0d exp e=%b t=%b edge=%0d", o.err, o.tmo, o.edge_n, e.err, e.tmo, e.edge_n); end
    end
  endtask

  task automatic test_back_to_back;
    rsp_t o, e; bit ok; int acc, ns0;
    logic [DW-1:0] wd, rd;
    logic w;
    ns0 = nonseq_cnt;
    for (int k = 0; k < 4; k++) begin
      w  = (k % 2) == 1;
      wd = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      HRDATA = rd;
      drive_req(w, 32'h0000_1000 + 32'(k * 16), wd, acc);
      push_exp(w ? '0 : rd, 1'b0, 1'b0, 1'b1, acc + 3);
      // A request raised while busy must be ignored, not queued
      req_valid = 1'b1; req_addr = 32'h0000_2000; req_write = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(20, ok);
      checks++;
      if (!ok) begin errors++; e = exp_q.pop_front(); $display("FAIL b2b_rsp[%0d] no response within budget", k); end
      else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo || o.edge_n !== e.edge_n) begin errors++; $display("FAIL b2b_rsp[%0d] got d=%h e=%b t=%b edge=%0d exp d=%h e=%b t=%b edge=%0d", k, o.rdata, o.err, o.tmo, o.edge_n, e.rdata, e.err, e.tmo, e.edge_n); end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (nonseq_cnt - ns0 !== 4 || obs_q.size() != 0) begin errors++; $display("FAIL b2b_ignored got nonseq=%0d extra_rsp=%0d exp 4 0", nonseq_cnt - ns0, obs_q.size()); end
    HRDATA = '0;
  endtask

  task automatic test_reset_mid;
    int acc, rs0;
    for (int ph = 0; ph < 2; ph++) begin
      rs0 = rsp_seen;
      drive_req(1'b1, SENSOR_ADDR, {4{32'h5A5A_5A5A}}, acc);
      if (ph == 0) HREADY = 1'b0;
      @(negedge clk);
      HREADY = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if ({HTRANS, HSELx, req_ready, rsp_valid} !== {2'b00, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_mid[%0d] got trans=%b sel=%b rdy=%b v=%b exp 00 0 0 0", ph, HTRANS, HSELx, req_ready, rsp_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0; HREADY = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready[%0d] got %b exp 1", ph, req_ready); end
      repeat (5) @(negedge clk);
      checks++; if (rsp_seen !== rs0 || obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_norsp[%0d] got rsp=%0d exp 0", ph, rsp_seen - rs0); end
    end
  endtask

  task automatic test_final;
    checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got exp=%0d obs=%0d exp 0 0", exp_q.size(), obs_q.size()); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rsp_flag_rules got %0d violations exp 0", viol); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    test_reset;
    test_write;
    test_read_wait;
    test_error;
    test_timeout;
    test_misaligned;
    test_back_to_back;
    test_reset_mid;
    test_final;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
